cpu_subsys_bus: RTL and testbench

Single-master, four-slave interconnect on the CPU native memory bus (valid/ready/addr/wdata/wstrb/rdata). It sits directly upstream of the boot ROM, RAM and peripheral slaves. It decodes the CPU address, forwards the request to one slave and returns that slave's response. Unmapped accesses, writes to ROM and hung slaves are terminated with an error response and a sticky error flag.

---
 rtl/cpu_subsys_pkg.sv | 31 +++
 rtl/cpu_subsys_bus_decode.sv | 47 ++++
 rtl/cpu_subsys_bus.sv | 162 ++++++++++++++++
 tb/tb_cpu_subsys_bus.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_subsys_pkg.sv
// Shared types and constants for the CPU native-bus interconnect:
// FSM state encoding, slave indices, address region nibbles and defaults.
package cpu_subsys_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } bus_state_e;

  localparam int NUM_SLAVES = 4;
  localparam int CNT_W      = 16;

  localparam logic [1:0] SLV_ROM    = 2'd0;
  localparam logic [1:0] SLV_RAM    = 2'd1;
  localparam logic [1:0] SLV_PERIPH = 2'd2;
  localparam logic [1:0] SLV_SPARE  = 2'd3;

  localparam logic [3:0] REGION_ROM    = 4'h0;
  localparam logic [3:0] REGION_RAM    = 4'h1;
  localparam logic [3:0] REGION_PERIPH = 4'h2;
  localparam logic [3:0] REGION_SPARE  = 4'h3;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hBADB_0005;

  // One-hot slave request vector for a given slave index.
  function automatic logic [NUM_SLAVES-1:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/cpu_subsys_bus_decode.sv
// Address decoder: maps the top address nibble to a slave index and flags
// unmapped regions and write attempts to the read-only boot ROM.
module cpu_subsys_bus_decode
  import cpu_subsys_pkg::*;
(
  input  logic [3:0] region,
  input  logic [3:0] wstrb,
  output logic [1:0] sel,
  output logic       hit,
  output logic       ro_violation
);

  // Region nibble to slave index; anything above the spare slave is unmapped.
  always_comb begin
    sel          = SLV_ROM;
    hit          = 1'b0;
    ro_violation = 1'b0;
    case (region)
      REGION_ROM: begin
        sel = SLV_ROM;
        hit = 1'b1;
      end
      REGION_RAM: begin
        sel = SLV_RAM;
        hit = 1'b1;
      end
      REGION_PERIPH: begin
        sel = SLV_PERIPH;
        hit = 1'b1;
      end
      REGION_SPARE: begin
        sel = SLV_SPARE;
        hit = 1'b1;
      end
      default: begin
        sel = SLV_ROM;
        hit = 1'b0;
      end
    endcase
    if (hit && (sel == SLV_ROM) && (wstrb != 4'b0000)) begin
      ro_violation = 1'b1;
    end else begin
      ro_violation = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_subsys_bus.sv
// Single-master, four-slave interconnect on the CPU native memory bus with
// error termination (unmapped, ROM write, slave timeout) and a sticky error flag.
module cpu_subsys_bus
  import cpu_subsys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         m_mem_valid,
  output logic         m_mem_ready,
  input  logic [31:0]  m_mem_addr,
  input  logic [31:0]  m_mem_wdata,
  input  logic [3:0]   m_mem_wstrb,
  output logic [31:0]  m_mem_rdata,
  output logic [3:0]   s_mem_valid,
  input  logic [3:0]   s_mem_ready,
  output logic [31:0]  s_mem_addr,
  output logic [31:0]  s_mem_wdata,
  output logic [3:0]   s_mem_wstrb,
  input  logic [127:0] s_mem_rdata,
  output logic         bus_err,
  output logic [31:0]  bus_err_addr,
  input  logic         bus_err_clr
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX      = 16'hFFFF;

  bus_state_e       state_r;
  bus_state_e       state_s;
  logic [1:0]       sel_r;
  logic [1:0]       dec_sel_s;
  logic             dec_hit_s;
  logic             dec_ro_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      slave_rdata_s;

  cpu_subsys_bus_decode u_decode (
    .region       (m_mem_addr[31:28]),
    .wstrb        (m_mem_wstrb),
    .sel          (dec_sel_s),
    .hit          (dec_hit_s),
    .ro_violation (dec_ro_s)
  );

  assign slave_rdata_s = s_mem_rdata[{sel_r, 5'd0} +: 32];

  // Next state plus the combinational request gate and response mux.
  // An abort (master drops valid) wins over a same-cycle slave ready.
  always_comb begin
    state_s     = state_r;
    m_mem_ready = 1'b0;
    m_mem_rdata = 32'h0000_0000;
    s_mem_valid = 4'b0000;
    case (state_r)
      IDLE: begin
        if (m_mem_valid) begin
          if (dec_hit_s && !dec_ro_s) begin
            state_s = ACTIVE;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (!m_mem_valid) begin
          state_s = IDLE;
        end else begin
          s_mem_valid = sel_onehot(sel_r);
          if (s_mem_ready[sel_r]) begin
            m_mem_ready = 1'b1;
            m_mem_rdata = slave_rdata_s;
            state_s     = IDLE;
          end else if (cnt_r >= TIMEOUT_LAST) begin
            state_s = ERR;
          end else begin
            state_s = ACTIVE;
          end
        end
      end
      ERR: begin
        m_mem_ready = 1'b1;
        m_mem_rdata = ERR_RDATA;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture on acceptance; the slave-side bus is held stable afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_mem_addr  <= 32'h0000_0000;
      s_mem_wdata <= 32'h0000_0000;
      s_mem_wstrb <= 4'b0000;
      sel_r       <= SLV_ROM;
    end else if ((state_r == IDLE) && m_mem_valid) begin
      s_mem_addr  <= m_mem_addr;
      s_mem_wdata <= m_mem_wdata;
      s_mem_wstrb <= m_mem_wstrb;
      sel_r       <= dec_sel_s;
    end else begin
      s_mem_addr  <= s_mem_addr;
      s_mem_wdata <= s_mem_wdata;
      s_mem_wstrb <= s_mem_wstrb;
      sel_r       <= sel_r;
    end
  end

  // Saturating ACTIVE-cycle counter, cleared whenever ACTIVE is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'h0000;
    end else if ((state_r == ACTIVE) && (state_s == ACTIVE)) begin
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= 16'h0000;
    end
  end

  // Sticky error flag; the address captures the first error since the last
  // clear, and a clear coinciding with a new error lets the new one through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err      <= 1'b0;
      bus_err_addr <= 32'h0000_0000;
    end else if (state_r == ERR) begin
      bus_err <= 1'b1;
      if (!bus_err || bus_err_clr) begin
        bus_err_addr <= s_mem_addr;
      end else begin
        bus_err_addr <= bus_err_addr;
      end
    end else if (bus_err_clr) begin
      bus_err      <= 1'b0;
      bus_err_addr <= bus_err_addr;
    end else begin
      bus_err      <= bus_err;
      bus_err_addr <= bus_err_addr;
    end
  end

endmodule

// File: tb/tb_cpu_subsys_bus.sv
// Scoreboard bench for cpu_subsys_bus: directed scenarios then random traffic,
// with a behavioural slave model and an independent error-flag model.
module tb_cpu_subsys_bus;

  localparam int          T     = 8;
  localparam logic [31:0] ERR_D = 32'hBADB_0005;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_mem_valid = 1'b0;
  logic         m_mem_ready;
  logic [31:0]  m_mem_addr = 32'h0;
  logic [31:0]  m_mem_wdata = 32'h0;
  logic [3:0]   m_mem_wstrb = 4'h0;
  logic [31:0]  m_mem_rdata;
  logic [3:0]   s_mem_valid;
  logic [3:0]   s_mem_ready = 4'h0;
  logic [31:0]  s_mem_addr;
  logic [31:0]  s_mem_wdata;
  logic [3:0]   s_mem_wstrb;
  logic [127:0] s_mem_rdata = 128'h0;
  logic         bus_err;
  logic [31:0]  bus_err_addr;
  logic         bus_err_clr = 1'b0;

  cpu_subsys_bus #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR_D)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_mem_valid(m_mem_valid), .m_mem_ready(m_mem_ready),
    .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata),
    .m_mem_wstrb(m_mem_wstrb), .m_mem_rdata(m_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_ready(s_mem_ready),
    .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata),
    .s_mem_wstrb(s_mem_wstrb), .s_mem_rdata(s_mem_rdata),
    .bus_err(bus_err), .bus_err_addr(bus_err_addr), .bus_err_clr(bus_err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          is_err;
    int          lat;
    int          stamp;
  } exp_t;

  exp_t sb[$];

  // Slave behaviour for the current transaction (0 = never answers).
  int          slv_delay = 0;
  logic [31:0] slv_data = 32'h0;
  bit          slv_hold = 1'b0;
  int          act_cnt = 0;
  int          hold_lane = -1;

  // What the slave side should see for the current request.
  logic [3:0]  cur_sv = 4'h0;
  logic [31:0] cur_addr = 32'h0;
  logic [31:0] cur_wdata = 32'h0;
  logic [3:0]  cur_wstrb = 4'h0;

  // Error-flag model.
  bit          m_err = 1'b0;
  logic [31:0] m_err_addr = 32'h0;

  // Slave model: answers the selected lane after slv_delay request cycles;
  // unselected lanes carry random ready noise and random data.
  always @(negedge clk) begin
    logic [3:0]   rdy;
    logic [127:0] rd;
    int           lane;
    #1;
    rdy  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    rd   = {$urandom, $urandom, $urandom, $urandom};
    lane = -1;
    for (int i = 0; i < 4; i++) if (s_mem_valid[i]) lane = i;
    if (lane >= 0) begin
      act_cnt++;
      rdy[lane] = 1'b0;
      if (act_cnt == slv_delay) begin
        rdy[lane] = 1'b1;
        rd[32*lane +: 32] = slv_data;
        hold_lane = slv_hold ? lane : -1;
      end
    end else begin
      act_cnt = 0;
      if (hold_lane >= 0) begin
        rdy[hold_lane] = 1'b1;
        hold_lane = -1;
      end
    end
    s_mem_ready = rdy;
    s_mem_rdata = rd;
  end

  // Monitor: pops the scoreboard on every response and tracks the error flag.
  always @(negedge clk) begin
    exp_t it;
    bit   err_done;
    #2;
    if (!rst_n) begin
      sb.delete();
      m_err      = 1'b0;
      m_err_addr = 32'h0;
    end else begin
      err_done = 1'b0;
      check("bus_err", 32'(bus_err), 32'(m_err));
      check("bus_err_addr", bus_err_addr, m_err_addr);
      if (s_mem_valid != 4'h0) begin
        check("s_mem_valid", 32'(s_mem_valid), 32'(cur_sv));
        check("s_mem_addr", s_mem_addr, cur_addr);
        check("s_mem_wdata", s_mem_wdata, cur_wdata);
        check("s_mem_wstrb", 32'(s_mem_wstrb), 32'(cur_wstrb));
      end
      if (m_mem_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready: got ready=1 expected ready=0 (cycle %0d)", cyc);
        end else begin
          it = sb.pop_front();
          check("rdata", m_mem_rdata, it.rdata);
          check("latency", 32'(cyc - it.stamp), 32'(it.lat));
          err_done = it.is_err;
        end
      end
      if (err_done) begin
        if (!m_err || bus_err_clr) m_err_addr = it.addr;
        m_err = 1'b1;
      end else if (bus_err_clr) begin
        m_err = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      m_mem_valid = 1'b0;
      bus_err_clr = 1'b0;
    end
  endtask

  task automatic clr_err();
    @(posedge clk); #1;
    m_mem_valid = 1'b0;
    bus_err_clr = 1'b1;
    @(posedge clk); #1;
    bus_err_clr = 1'b0;
  endtask

  // Issue one request; expected response derived from the address map rules.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                        input int dly, input logic [31:0] data, input bit hold, input bit clr);
    exp_t       it;
    bit         map_err;
    logic [3:0] region;
    int         waited;
    region  = a[31:28];
    map_err = (region > 4'd3) || ((region == 4'd0) && (ws != 4'd0));
    it.addr = a;
    if (map_err) begin
      it.rdata = ERR_D; it.is_err = 1'b1; it.lat = 1;
    end else if (dly >= 1 && dly <= T) begin
      it.rdata = data; it.is_err = 1'b0; it.lat = dly;
    end else begin
      it.rdata = ERR_D; it.is_err = 1'b1; it.lat = T + 1;
    end
    @(posedge clk); #1;
    slv_delay = map_err ? 0 : dly;
    slv_data  = data;
    slv_hold  = hold;
    cur_sv    = map_err ? 4'h0 : (4'b0001 << region[1:0]);
    cur_addr  = a;
    cur_wdata = wd;
    cur_wstrb = ws;
    it.stamp  = cyc;
    sb.push_back(it);
    m_mem_valid = 1'b1;
    m_mem_addr  = a;
    m_mem_wdata = wd;
    m_mem_wstrb = ws;
    bus_err_clr = clr;
    waited = 0;
    while (waited < 40) begin
      @(negedge clk); #3;
      if (m_mem_ready) break;
      waited++;
    end
    if (waited == 40) begin
      total++;
      bad++;
      $display("FAIL no_response: got no ready for addr %h expected one within %0d cycles", a, T + 1);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rg;
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ready", 32'(m_mem_ready), 32'h0);
    check("rst_m_rdata", m_mem_rdata, 32'h0);
    check("rst_s_valid", 32'(s_mem_valid), 32'h0);
    check("rst_s_addr", s_mem_addr, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_err_addr", bus_err_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    do_txn(32'h0000_0010, 4'h0, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
    idle(1);
    do_txn(32'h1000_0004, 4'b0011, 32'hAABB_CCDD, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
    idle(1);
    check("no_err_yet", 32'(bus_err), 32'h0);
    do_txn(32'h8000_0000, 4'h0, 32'h0, 2, 32'h0, 1'b0, 1'b0);
    idle(1);
    check("unmapped_err", 32'(bus_err), 32'h1);
    check("unmapped_addr", bus_err_addr, 32'h8000_0000);
    clr_err();
    do_txn(32'h0000_0000, 4'b1111, 32'h5555_AAAA, 2, 32'h0, 1'b0, 1'b0);
    idle(1);
    check("romwr_addr", bus_err_addr, 32'h0000_0000);
    clr_err();
    do_txn(32'h2000_0040, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    idle(1);
    check("timeout_addr", bus_err_addr, 32'h2000_0040);
    do_txn(32'hC000_0000, 4'h0, 32'h0, 2, 32'h0, 1'b0, 1'b0);
    idle(1);
    check("first_err_kept", bus_err_addr, 32'h2000_0040);
    clr_err();
    check("err_cleared", 32'(bus_err), 32'h0);

    do_txn(32'h0000_0100, 4'h0, 32'h0, 2, 32'h1111_2222, 1'b1, 1'b0);
    do_txn(32'h0000_0104, 4'h0, 32'h0, 2, 32'h3333_4444, 1'b0, 1'b0);
    do_txn(32'h3000_0008, 4'h0, 32'h0, 1, 32'h5555_6666, 1'b0, 1'b0);
    idle(3);

    // Abort: master drops valid while the slave is still busy.
    @(posedge clk); #1;
    slv_delay = 0; cur_sv = 4'b0010; cur_addr = 32'h1000_0020;
    cur_wdata = 32'h0; cur_wstrb = 4'h0;
    m_mem_valid = 1'b1; m_mem_addr = 32'h1000_0020; m_mem_wdata = 32'h0; m_mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    m_mem_valid = 1'b0;
    idle(3);
    do_txn(32'h1000_0024, 4'h0, 32'h0, 3, 32'h7777_8888, 1'b0, 1'b0);
    idle(1);

    // Reset in the middle of an ACTIVE transfer with the error flag set.
    do_txn(32'hF000_0000, 4'h0, 32'h0, 2, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    slv_delay = 0; cur_sv = 4'b0010; cur_addr = 32'h1000_0030;
    cur_wdata = 32'hDEAD_BEEF; cur_wstrb = 4'hF;
    m_mem_valid = 1'b1; m_mem_addr = 32'h1000_0030; m_mem_wdata = 32'hDEAD_BEEF; m_mem_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_ready", 32'(m_mem_ready), 32'h0);
    check("mid_rst_s_valid", 32'(s_mem_valid), 32'h0);
    check("mid_rst_s_addr", s_mem_addr, 32'h0);
    check("mid_rst_s_wdata", s_mem_wdata, 32'h0);
    check("mid_rst_s_wstrb", 32'(s_mem_wstrb), 32'h0);
    check("mid_rst_bus_err", 32'(bus_err), 32'h0);
    check("mid_rst_err_addr", bus_err_addr, 32'h0);
    m_mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7) rg = 4'($urandom_range(0, 3));
      else rg = 4'($urandom_range(4, 15));
      ra = {rg, 28'($urandom)};
      do_txn(ra, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom,
             $urandom_range(0, 10), $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
